// File: rtl/scroll_display_if.sv
// scroll_display_if: button input and seven-segment display outputs of scroll_display_ctrl.
interface scroll_display_if;
  logic       new_button;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] pos;
  modport master (output new_button, input an, seg, dp, pos);
  modport slave  (input new_button, output an, seg, dp, pos);
endinterface

// File: rtl/scroll_display_ctrl.sv
// scroll_display_ctrl: 4-digit multiplexed hex window onto MSG, scrolled one character per press.
// Define AUTO_SCROLL_EN for timed auto-scroll where a press toggles run/pause.
module scroll_display_ctrl #(
  parameter int          REFRESH_DIV = 16384,
  parameter logic [63:0] MSG         = 64'h0123456789ABCDEF,
  parameter int          AUTO_DIV    = 50000000
) (
  input logic             clk,
  input logic             reset,
  scroll_display_if.slave dsp
);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam logic [RW-1:0] REF_TC = RW'(REFRESH_DIV - 1);
  localparam logic [111:0] HEX = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };
  logic          sync1_q, sync2_q, prev_q, armed_q;
  logic [1:0]    fill_q;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [1:0]    dsel_q, dsel_d;
  logic [3:0]    pos_q, pos_d, idx, an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic [63:0]   msg_sh;
  logic          step, adv, rtc;
  // armed_q only sets once a low has been seen through the synchroniser, so a
  // button already held across reset release cannot count as a fresh press
  assign step   = sync2_q & ~prev_q & armed_q;
  assign rtc    = rcnt_q == REF_TC;
  assign idx    = pos_q + {2'b00, dsel_q};
  assign msg_sh = MSG << {idx, 2'b00};
  always_comb begin
    rcnt_d = rtc ? '0 : rcnt_q + 1'b1;
    dsel_d = rtc ? dsel_q + 2'd1 : dsel_q;
    pos_d  = adv ? pos_q + 4'd1 : pos_q;
    an_d   = ~(4'b1000 >> dsel_q);
    seg_d  = HEX[msg_sh[63:60]*7 +: 7];
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      fill_q  <= 2'b00;
      armed_q <= 1'b0;
      rcnt_q  <= '0;
      dsel_q  <= 2'd0;
      pos_q   <= 4'd0;
      an_q    <= 4'b1111;
      seg_q   <= 7'b1111111;
    end else begin
      sync1_q <= dsp.new_button;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      fill_q  <= {fill_q[0], 1'b1};
      armed_q <= armed_q | (fill_q[1] & ~sync2_q);
      rcnt_q  <= rcnt_d;
      dsel_q  <= dsel_d;
      pos_q   <= pos_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
`ifdef AUTO_SCROLL_EN
  localparam int AW = $clog2(AUTO_DIV);
  logic [AW-1:0] acnt_q, acnt_d;
  logic          run_q, atc;
  // a press on the auto terminal-count edge toggles run and suppresses the advance
  assign atc    = acnt_q == AW'(AUTO_DIV - 1);
  assign acnt_d = (atc | step) ? '0 : acnt_q + 1'b1;
  assign adv    = run_q & atc & ~step;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      acnt_q <= '0;
      run_q  <= 1'b1;
    end else begin
      acnt_q <= acnt_d;
      run_q  <= run_q ^ step;
    end
`else
  assign adv = step;
`endif
  assign dsp.an  = an_q;
  assign dsp.seg = seg_q;
  assign dsp.dp  = 1'b1;
  assign dsp.pos = pos_q;
endmodule

// File: tb/tb_scroll_display_ctrl.sv
// tb_scroll_display_ctrl: directed plus randomized press stimulus against a cycle-count reference model.
module tb_scroll_display_ctrl;
  localparam int          RD  = 4;
  localparam logic [63:0] MSG = 64'h0123456789ABCDEF;
  logic clk = 1'b0;
  logic reset = 1'b0;
  scroll_display_if bus();
  scroll_display_ctrl #(.REFRESH_DIV(RD), .MSG(MSG)) dut (.clk(clk), .reset(reset), .dsp(bus.slave));
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  int n = 0;
  int pos_m = 0;
  logic h [0:4095];
  logic [6:0] hex_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  logic [3:0] an_tab [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

  function automatic logic [3:0] chr(input int i);
    logic [63:0] m;
    m = MSG;
    return m[63-4*(i%16) -: 4];
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (edge %0d)", tag, o, e, n);
    end
  endtask

  // Edges are numbered from 1 after reset release; a press whose first high
  // sample is at edge E (with a low sample at E-1, E>=2) moves pos at edge E+2,
  // and the registered display at edge k shows the digit/pos valid before k.
  task automatic cyc(input logic b);
    int pb, d;
    bus.new_button = b;
    @(posedge clk);
    n++;
    h[n] = b;
    pb = pos_m;
    if (n >= 4 && h[n-2] && !h[n-3]) pos_m = (pos_m + 1) % 16;
    d = ((n - 1) / RD) % 4;
    #1;
    chk("an", bus.an, an_tab[d]);
    chk("seg", bus.seg, hex_tab[chr(pb + d)]);
    chk("pos", bus.pos, pos_m);
    chk("dp", bus.dp, 1);
    chk("one_anode", $countones(~bus.an), 1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_an"}, bus.an, 4'b1111);
    chk({tag, "_seg"}, bus.seg, 7'b1111111);
    chk({tag, "_dp"}, bus.dp, 1);
    chk({tag, "_pos"}, bus.pos, 0);
  endtask

  initial begin
    bus.new_button = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk_reset("in_reset");
    reset = 1'b1;
    n = 0;
    pos_m = 0;
    repeat (8) cyc(1'b0);
    repeat (200) cyc(1'b1);
    repeat (5) cyc(1'b0);
    chk("long_hold_pos", bus.pos, 1);
    repeat (16) begin
      repeat (3) cyc(1'b1);
      repeat (3) cyc(1'b0);
    end
    chk("wrap_pos", bus.pos, 1);
    cyc(1'b0);
    while (((n + 3) % RD) != 0) cyc(1'b0);
    repeat (2) cyc(1'b1);
    repeat (6) cyc(1'b0);
    repeat (40) begin
      repeat ($urandom_range(1, 6)) cyc(1'b1);
      repeat ($urandom_range(1, 6)) cyc(1'b0);
    end
    for (int g = 0; g < 40 && pos_m != 9; g++) begin
      repeat (2) cyc(1'b1);
      repeat (2) cyc(1'b0);
    end
    chk("reach_9", bus.pos, 9);
    bus.new_button = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk_reset("async_reset");
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    n = 0;
    pos_m = 0;
    repeat (20) cyc(1'b1);
    chk("held_at_release", bus.pos, 0);
    repeat (3) cyc(1'b0);
    repeat (3) cyc(1'b1);
    repeat (5) cyc(1'b0);
    chk("after_release_press", bus.pos, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/scroll_display_ctrl.md
Name: scroll_display_ctrl

Overview:
- Downstream consumer of the debounced button pulse.
- Drives a 4-digit, common-anode, time-multiplexed seven-segment display with a window onto a 16-character hex message.
- Each debounced press scrolls the window left by one character.
- Resynchronises and edge-detects the incoming pulse so one press gives exactly one step, however many clk cycles the pulse lasts.

Parameters:
- REFRESH_DIV, 16384: clk cycles each digit stays lit before the next digit is selected; legal range 2..2^20.
- MSG, 64'h0123456789ABCDEF: message of 16 hex nibbles; character i = MSG[63-4i -: 4].
- AUTO_DIV, 50000000: clk cycles per automatic step; used only with AUTO_SCROLL_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- new_button  in  1  debounced press pulse; may be high for many clk cycles; not synchronous to clk
- an  out  4  digit anodes, active-low; an[3] = leftmost digit (digit 0)
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low; always 1 (off)
- pos  out  4  current message index shown on digit 0

Behaviour:
- Reset asserted (async): an=4'b1111, seg=7'b1111111, dp=1, pos=0, digit_sel=0, refresh counter=0; sync/edge flops=0.
- Input path: new_button -> sync1 -> sync2 -> prev.
  - step = sync2 & ~prev.
  - Rise sampled at edge E: pos increments at edge E+2.
  - Registered display outputs reflect the new pos at edge E+3.
- Held input: exactly one step per rising edge; input already high when reset releases gives no step.
- pos: 4-bit, modulo 16; 15 -> 0 on step.
- Refresh:
  - Counter runs 0..REFRESH_DIV-1.
  - At terminal count it clears and digit_sel advances 0->1->2->3->0.
  - States: DIG0 (an=0111), DIG1 (1011), DIG2 (1101), DIG3 (1110).
- Output registers, loaded every clk from current digit_sel and pos:
  - an = one-hot-low for digit_sel.
  - seg = decode of character (pos + digit_sel) mod 16.
  - First edge after reset release: an=0111, seg=decode(MSG char pos).
- Hex decode (active-low {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Step coinciding with refresh terminal count: both take effect on the same edge; no glitch to an=1111 between digits.
- Never more than one anode low at any time.
- Reset mid-scroll or mid-refresh: immediate return to reset values; pending edge discarded.

Optional Feature:
- Macro: AUTO_SCROLL_EN.
- Defined:
  - Adds an auto counter 0..AUTO_DIV-1 and a run flag (reset value 1).
  - pos steps at each auto terminal count while run=1.
  - A button step toggles run instead of advancing pos; auto counter clears on toggle.
  - Auto terminal count and button step on the same edge: toggle wins, no advance.
- Not defined: no auto counter or run flag; every button step advances pos.

Test Plan:
- Reset low 5 cycles then release, REFRESH_DIV=4 -> an=1111/seg=1111111 during reset; first edge an=0111, seg=1000000 ('0'); an rotates 0111,1011,1101,1110 every 4 cycles.
- new_button high for 200 cycles -> pos 0->1 once, 3 edges after the sampled rise; digit 0 then shows 1111001.
- 16 separate pulses -> pos cycles 1..15 then wraps to 0; at pos=14 the digits show E,F,0,1 (0000110,0001110,1000000,1111001).
- new_button pulse arriving on the refresh terminal-count edge -> pos and digit_sel advance together; no cycle with two anodes low or all anodes high.
- Reset asserted mid-scroll at pos=9 -> outputs go to reset values asynchronously; after release pos=0, no spurious step even though new_button is still high.
- AUTO_SCROLL_EN defined, AUTO_DIV=10 -> pos increments every 10 cycles; one press stops increments; a second press resumes them 10 cycles later.
